sdram_pro_write: RTL

- Write-path engine for the SDRAM controller.
- Raises `wr_req` to the arbiter when the write FIFO holds a burst's worth of data.
- On the arbiter's `wr_en` grant it runs one full-page-mode burst: ACTIVE, WRITE with data, BURST STOP, then PRECHARGE.
- Returns `wr_end`/`wr_cmd`/`wr_bank`/`wr_addr` to the arbiter and advances an internal wrapping write pointer.

---
 rtl/sdram_pro_write_pkg.sv | 28 ++
 rtl/sdram_pro_write.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_pro_write_pkg.sv
// Shared SDRAM controller definitions: command encodings, address field widths,
// timing defaults and the burst-length helper used by the write engine.
package sdram_pro_write_pkg;

    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_BST       = 4'b0110;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;

    localparam int BANK_W = 2;
    localparam int ROW_W  = 12;
    localparam int COL_W  = 8;
    localparam int ADDR_W = BANK_W + ROW_W + COL_W;

    localparam int TRCD_CLK_DEF = 2;
    localparam int TWR_CLK_DEF  = 2;
    localparam int TRP_CLK_DEF  = 2;

    // A10 high on PRECHARGE selects all banks
    localparam logic [ROW_W-1:0] A10_ALL_BANKS = 12'h400;

    // A burst length field of zero means a full 256-word page
    function automatic logic [8:0] burst_words(input logic [8:0] len);
        burst_words = (len == 9'd0) ? 9'd256 : len;
    endfunction

endpackage

// File: rtl/sdram_pro_write.sv
// SDRAM write-path engine: requests the bus when the FIFO holds a burst, then runs
// ACTIVE / WRITE / BURST STOP / PRECHARGE in full-page mode and advances a wrapping pointer.
module sdram_pro_write
    import sdram_pro_write_pkg::*;
#(
    parameter int                TRCD_CLK   = TRCD_CLK_DEF,
    parameter int                TWR_CLK    = TWR_CLK_DEF,
    parameter int                TRP_CLK    = TRP_CLK_DEF,
    parameter logic [ADDR_W-1:0] ADDR_START = 22'h000000,
    parameter logic [ADDR_W-1:0] ADDR_END   = 22'h3FFFFF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              wr_en,
    input  logic              data_ready,
    input  logic [8:0]        burst_len,
    input  logic [15:0]       wr_data,
    output logic              wr_req,
    output logic              wr_end,
    output logic [3:0]        wr_cmd,
    output logic [BANK_W-1:0] wr_bank,
    output logic [ROW_W-1:0]  wr_addr,
    output logic              wr_data_req,
    output logic              wr_data_valid,
    output logic [15:0]       wr_sdram_data
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACT,
        ST_TRCD,
        ST_DATA,
        ST_BST,
        ST_TWR,
        ST_PRE,
        ST_TRP
    } state_t;

    localparam logic [8:0] TRCD_LOAD = 9'(TRCD_CLK - 2);
    localparam logic [8:0] TWR_LOAD  = 9'(TWR_CLK - 1);
    localparam logic [8:0] TRP_LOAD  = 9'(TRP_CLK - 1);

    state_t              state_r;
    state_t              state_s;
    logic [8:0]          cnt_r;
    logic [8:0]          cnt_s;
    logic                wr_en_d_r;
    logic [8:0]          blen_r;
    logic [ADDR_W-1:0]   ptr_r;
    logic [ADDR_W-1:0]   ptr_s;
    logic [ADDR_W:0]     sum_s;
    logic                start_s;

    logic                wr_req_r;
    logic                wr_req_s;
    logic                wr_end_r;
    logic                wr_end_s;
    logic [3:0]          wr_cmd_r;
    logic [3:0]          wr_cmd_s;
    logic [BANK_W-1:0]   wr_bank_r;
    logic [BANK_W-1:0]   wr_bank_s;
    logic [ROW_W-1:0]    wr_addr_r;
    logic [ROW_W-1:0]    wr_addr_s;
    logic                wr_data_req_r;
    logic                wr_data_req_s;
    logic                wr_data_valid_r;
    logic                wr_data_valid_s;
    logic [15:0]         wr_sdram_data_r;

    // Only a fresh grant edge starts a burst, so a grant left high after wr_end is ignored
    assign start_s = (state_r == ST_IDLE) && wr_req_r && wr_en && !wr_en_d_r;

    // Next state and the single timing counter, reloaded on every state entry
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_s = ST_ACT;
                    cnt_s   = 9'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACT: begin
                if (TRCD_CLK > 1) begin
                    state_s = ST_TRCD;
                    cnt_s   = TRCD_LOAD;
                end else begin
                    state_s = ST_DATA;
                    cnt_s   = blen_r - 9'd1;
                end
            end
            ST_TRCD: begin
                if (cnt_r == 9'd0) begin
                    state_s = ST_DATA;
                    cnt_s   = blen_r - 9'd1;
                end else begin
                    cnt_s = cnt_r - 9'd1;
                end
            end
            ST_DATA: begin
                if (cnt_r == 9'd0) begin
                    state_s = ST_BST;
                    cnt_s   = 9'd0;
                end else begin
                    cnt_s = cnt_r - 9'd1;
                end
            end
            ST_BST: begin
                state_s = ST_TWR;
                cnt_s   = TWR_LOAD;
            end
            ST_TWR: begin
                if (cnt_r == 9'd0) begin
                    state_s = ST_PRE;
                    cnt_s   = 9'd0;
                end else begin
                    cnt_s = cnt_r - 9'd1;
                end
            end
            ST_PRE: begin
                state_s = ST_TRP;
                cnt_s   = TRP_LOAD;
            end
            ST_TRP: begin
                if (cnt_r == 9'd0) begin
                    state_s = ST_IDLE;
                    cnt_s   = 9'd0;
                end else begin
                    cnt_s = cnt_r - 9'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 9'd0;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so the registers line up with it
    always_comb begin
        wr_cmd_s        = CMD_NOP;
        wr_addr_s       = {ROW_W{1'b0}};
        wr_bank_s       = (state_s != ST_IDLE) ? ptr_r[ADDR_W-1 -: BANK_W] : {BANK_W{1'b0}};
        wr_data_valid_s = (state_s == ST_DATA);
        wr_end_s        = (state_s == ST_TRP) && (cnt_s == 9'd0);
        // FIFO pops run one cycle ahead of the data beats
        wr_data_req_s   = ((state_s == ST_DATA) && (cnt_s != 9'd0)) ||
                          ((state_s == ST_TRCD) && (cnt_s == 9'd0)) ||
                          ((state_s == ST_ACT) && (TRCD_CLK == 1));
        case (state_s)
            ST_ACT: begin
                wr_cmd_s  = CMD_ACTIVE;
                wr_addr_s = ptr_r[COL_W +: ROW_W];
            end
            ST_DATA: begin
                if (state_r != ST_DATA) begin
                    wr_cmd_s  = CMD_WRITE;
                    wr_addr_s = {{(ROW_W-COL_W){1'b0}}, ptr_r[0 +: COL_W]};
                end else begin
                    wr_cmd_s = CMD_NOP;
                end
            end
            ST_BST: begin
                wr_cmd_s = CMD_BST;
            end
            ST_PRE: begin
                wr_cmd_s  = CMD_PRECHARGE;
                wr_addr_s = A10_ALL_BANKS;
            end
            default: begin
                wr_cmd_s = CMD_NOP;
            end
        endcase
    end

    // Request and pointer bookkeeping; the wider sum keeps the end-of-range test exact
    always_comb begin
        sum_s = {1'b0, ptr_r} + {{(ADDR_W-8){1'b0}}, blen_r};
        if (sum_s > {1'b0, ADDR_END}) begin
            ptr_s = ADDR_START;
        end else begin
            ptr_s = sum_s[ADDR_W-1:0];
        end
        if (wr_end_r) begin
            wr_req_s = 1'b0;
        end else if ((state_r == ST_IDLE) && data_ready) begin
            wr_req_s = 1'b1;
        end else begin
            wr_req_s = wr_req_r;
        end
    end

    // Sequencer state, grant edge detector, sampled burst length and write pointer
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 9'd0;
            wr_en_d_r <= 1'b0;
            blen_r    <= 9'd1;
            ptr_r     <= ADDR_START;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            wr_en_d_r <= wr_en;
            if (start_s) begin
                blen_r <= burst_words(burst_len);
            end
            if (wr_end_r) begin
                ptr_r <= ptr_s;
            end
        end
    end

    // Registered arbiter and SDRAM-side outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_req_r        <= 1'b0;
            wr_end_r        <= 1'b0;
            wr_cmd_r        <= CMD_NOP;
            wr_bank_r       <= {BANK_W{1'b0}};
            wr_addr_r       <= {ROW_W{1'b0}};
            wr_data_req_r   <= 1'b0;
            wr_data_valid_r <= 1'b0;
            wr_sdram_data_r <= 16'h0000;
        end else begin
            wr_req_r        <= wr_req_s;
            wr_end_r        <= wr_end_s;
            wr_cmd_r        <= wr_cmd_s;
            wr_bank_r       <= wr_bank_s;
            wr_addr_r       <= wr_addr_s;
            wr_data_req_r   <= wr_data_req_s;
            wr_data_valid_r <= wr_data_valid_s;
            if (wr_data_req_r) begin
                wr_sdram_data_r <= wr_data;
            end
        end
    end

    assign wr_req        = wr_req_r;
    assign wr_end        = wr_end_r;
    assign wr_cmd        = wr_cmd_r;
    assign wr_bank       = wr_bank_r;
    assign wr_addr       = wr_addr_r;
    assign wr_data_req   = wr_data_req_r;
    assign wr_data_valid = wr_data_valid_r;
    assign wr_sdram_data = wr_sdram_data_r;

endmodule
